mem_stage_ctrl: RTL and testbench

Memory-stage access controller for the ARM pipeline. It takes the memory request carried out of the EXE/MEM pipeline register and sequences each 32-bit load or store as two 16-bit accesses on the external SRAM. While an access is in progress it deasserts `ready`, which freezes every pipeline register. It returns the assembled 32-bit load data to the write-back path.

---
 rtl/mem_stage_if.sv | 31 +++
 rtl/mem_stage_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Memory-stage bundle: pipeline request/response on one side, 16-bit SRAM bus on the other.
// The master modport is the environment (pipeline + SRAM); the slave modport is the controller.
interface mem_stage_if #(
  parameter int BIT_NUMBER = 32
);
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic [BIT_NUMBER-1:0] address;
  logic [BIT_NUMBER-1:0] st_val;
  logic                  ready;
  logic [BIT_NUMBER-1:0] rd_data;
  logic [17:0]           sram_addr;
  logic [15:0]           sram_dq_out;
  logic                  sram_dq_oe;
  logic                  sram_we_n;
  logic [15:0]           sram_dq_in;
  logic [1:0]            dbg_state;

  // Handshake: ready is the only flow control. While a request is held and
  // ready=0 the pipeline is frozen and mem_r_en/mem_w_en/address/st_val must
  // stay stable; the access is complete in the cycle where ready=1 (rd_data valid).
  modport master (
    output mem_r_en, mem_w_en, address, st_val, sram_dq_in,
    input  ready, rd_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, dbg_state
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, st_val, sram_dq_in,
    output ready, rd_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, dbg_state
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two timed 16-bit SRAM
// accesses and stalls the pipeline (ready=0) until the word is done.
module mem_stage_ctrl #(
  parameter int BIT_NUMBER  = 32,
  parameter int ADDR_OFFSET = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0]            CNT_LAST    = 4'(WAIT_CYCLES - 1);
  localparam logic [BIT_NUMBER-1:0] OFFSET_BASE = BIT_NUMBER'(ADDR_OFFSET);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [15:0]           low_half;
  logic [BIT_NUMBER-1:0] rd_q;
  logic                  req;
  logic                  is_store;
  logic                  is_load;
  logic                  term;
  logic [BIT_NUMBER-1:0] offset;
  logic [16:0]           word;
  logic                  unused_offset_bits;

  // A simultaneous read+write request is treated as a store only.
  assign req      = bus.mem_r_en | bus.mem_w_en;
  assign is_store = bus.mem_w_en;
  assign is_load  = bus.mem_r_en & ~bus.mem_w_en;
  assign term     = (cnt == CNT_LAST);

  assign offset             = bus.address - OFFSET_BASE;
  assign word               = offset[18:2];
  assign unused_offset_bits = ^{offset[BIT_NUMBER-1:19], offset[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      low_half <= '0;
      rd_q     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == LOW && term && is_load) begin
        low_half <= bus.sram_dq_in;
      end
      if (state == HIGH && term && is_load) begin
        rd_q <= BIT_NUMBER'({bus.sram_dq_in, low_half});
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        if (term) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HIGH: begin
        if (term) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      // The pipeline advances on the DONE edge, so never relaunch from here.
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    bus.ready       = ~req | (state == DONE);
    bus.sram_addr   = '0;
    bus.sram_we_n   = 1'b1;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_dq_out = '0;
    if (state == LOW || state == HIGH) begin
      bus.sram_addr = {word, (state == HIGH)};
      if (is_store) begin
        bus.sram_we_n   = 1'b0;
        bus.sram_dq_oe  = 1'b1;
        bus.sram_dq_out = (state == HIGH) ? bus.st_val[31:16] : bus.st_val[15:0];
      end
    end
  end

  assign bus.rd_data   = rd_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table-driven vectors, hand-written corner sequences and
// random traffic checked against a word-level memory model and a 16-bit SRAM model.
module tb_mem_stage_ctrl;

  localparam int W    = 2;
  localparam int BUSY = 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_if #(.BIT_NUMBER(32)) bus ();

  mem_stage_ctrl #(
    .BIT_NUMBER (32),
    .ADDR_OFFSET(1024),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural asynchronous-read, synchronous-write 16-bit SRAM.
  logic [15:0] sram_mem [0:262143];
  always @(posedge clk) begin
    if (!bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
  end
  assign bus.sram_dq_in = sram_mem[bus.sram_addr];

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] ref_rd = 32'h0;

  logic [17:0] rec_addr [0:15];
  logic        rec_we   [0:15];
  logic        rec_oe   [0:15];
  logic [15:0] rec_dq   [0:15];
  int          rec_n;
  int          done_cyc;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] val;
    logic [31:0] exp_rd;
    logic [17:0] exp_saddr;
    int          exp_we;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Word index seen by the SRAM: byte offset from 1024, wrapping at 32 bits, in 4-byte units.
  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 32'd4) % 32'd131072);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    @(negedge clk);
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Called on a negedge with the request already applied; samples every cycle until ready.
  task automatic wait_done(output int busy, output logic [31:0] rd);
    busy  = 0;
    rd    = '0;
    rec_n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (rec_n < 16) begin
        rec_addr[rec_n] = bus.sram_addr;
        rec_we[rec_n]   = bus.sram_we_n;
        rec_oe[rec_n]   = bus.sram_dq_oe;
        rec_dq[rec_n]   = bus.sram_dq_out;
        rec_n++;
      end
      if (bus.ready) begin
        rd       = bus.rd_data;
        done_cyc = cyc;
        break;
      end
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] v, output int busy, output logic [31:0] rd);
    @(negedge clk);
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.address  = a;
    bus.st_val   = v;
    wait_done(busy, rd);
  endtask

  task automatic run_txn(input string nm, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] v, output logic [31:0] rd);
    int k;
    int busy;
    k = word_of(a);
    if (w) ref_mem[k] = v;
    else if (r) ref_rd = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    exp_q.push_back(ref_rd);
    do_access(r, w, a, v, busy, rd);
    check({nm, " rd_data"}, rd, exp_q.pop_front());
    check({nm, " busy"}, 32'(busy), 32'(BUSY));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  initial begin
    logic [31:0] rd;
    int          busy;
    int          we_cnt;
    int          first_done;
    logic [17:0] ea;

    vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h00000000, 18'd4,       4};
    vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hDEADBEEF, 18'd4,       0};
    vecs[2] = '{1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'hDEADBEEF, 18'd8,       4};
    vecs[3] = '{1'b1, 1'b0, 32'd1040, 32'h00000000, 32'hCAFEF00D, 18'd8,       0};
    vecs[4] = '{1'b0, 1'b1, 32'd1033, 32'h0BADF00D, 32'hCAFEF00D, 18'd4,       4};
    vecs[5] = '{1'b1, 1'b0, 32'd1034, 32'h00000000, 32'h0BADF00D, 18'd4,       0};
    vecs[6] = '{1'b0, 1'b1, 32'd0,    32'hA5A55A5A, 32'h0BADF00D, 18'h3FE00,   4};
    vecs[7] = '{1'b1, 1'b0, 32'd3,    32'h00000000, 32'hA5A55A5A, 18'h3FE00,   0};

    rst          = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address  = '0;
    bus.st_val   = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset we_n", 32'(bus.sram_we_n), 32'd1);
    check("reset state", 32'(bus.dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle: nothing happens on the bus for 10 cycles.
    repeat (10) @(negedge clk);
    #1;
    check("idle ready", 32'(bus.ready), 32'd1);
    check("idle we_n", 32'(bus.sram_we_n), 32'd1);
    check("idle oe", 32'(bus.sram_dq_oe), 32'd0);
    check("idle sram_addr", 32'(bus.sram_addr), 32'd0);
    check("idle dq_out", 32'(bus.sram_dq_out), 32'd0);
    check("idle rd_data", bus.rd_data, 32'd0);

    // Table-driven vectors: latency, per-phase SRAM drive and returned data.
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].val, rd);
      check($sformatf("vec%0d table rd", i), rd, vecs[i].exp_rd);
      we_cnt = 0;
      for (int j = 0; j < rec_n; j++) if (!rec_we[j]) we_cnt++;
      check($sformatf("vec%0d we cycles", i), 32'(we_cnt), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d idle addr", i), 32'(rec_addr[0]), 32'd0);
      check($sformatf("vec%0d done addr", i), 32'(rec_addr[2*W+1]), 32'd0);
      for (int j = 1; j <= 2 * W; j++) begin
        ea = vecs[i].exp_saddr + ((j > W) ? 18'd1 : 18'd0);
        check($sformatf("vec%0d addr c%0d", i, j), 32'(rec_addr[j]), 32'(ea));
        check($sformatf("vec%0d oe c%0d", i, j), 32'(rec_oe[j]), 32'(vecs[i].w));
        if (vecs[i].w)
          check($sformatf("vec%0d dq c%0d", i, j), 32'(rec_dq[j]),
                32'((j > W) ? vecs[i].val[31:16] : vecs[i].val[15:0]));
      end
      idle(1);
    end

    // Back-to-back: load then store presented on the cycle after DONE.
    run_txn("b2b load", 1'b1, 1'b0, 32'd1032, 32'h0, rd);
    first_done = done_cyc;
    run_txn("b2b store", 1'b0, 1'b1, 32'd1036, 32'h12345678, rd);
    check("b2b spacing", 32'(done_cyc - first_done), 32'(2 * W + 2));
    idle(1);
    check("b2b sram[6]", 32'(sram_mem[6]), 32'h5678);
    check("b2b sram[7]", 32'(sram_mem[7]), 32'h1234);

    // Reset in the HIGH phase of a store, request held across reset.
    @(negedge clk);
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b1;
    bus.address  = 32'd1044;
    bus.st_val   = 32'h11112222;
    repeat (3) @(negedge clk);
    #1;
    check("rst pre state", 32'(bus.dbg_state), 32'd2);
    check("rst pre we_n", 32'(bus.sram_we_n), 32'd0);
    rst = 1'b1;
    #1;
    check("rst we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst oe", 32'(bus.sram_dq_oe), 32'd0);
    check("rst sram_addr", 32'(bus.sram_addr), 32'd0);
    check("rst state", 32'(bus.dbg_state), 32'd0);
    check("rst rd_data", bus.rd_data, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    ref_rd = 32'h0;
    ref_mem[word_of(32'd1044)] = 32'h11112222;
    wait_done(busy, rd);
    check("rst restart busy", 32'(busy), 32'(BUSY));
    check("rst restart rd", rd, 32'h0);
    idle(1);
    run_txn("rst readback", 1'b1, 1'b0, 32'd1044, 32'h0, rd);
    idle(1);

    // Random traffic against the word-level model.
    for (int t = 0; t < 40; t++) begin
      int          k;
      int          op;
      int          gap;
      logic [31:0] a;
      logic [31:0] v;
      k  = $urandom_range(0, 15);
      op = $urandom_range(0, 2);
      a  = 32'd1024 + 32'(4 * k) + 32'($urandom_range(0, 3));
      v  = $urandom;
      if (op == 0 && !ref_mem.exists(word_of(a))) op = 1;
      run_txn($sformatf("rand%0d", t), (op != 1), (op != 0), a, v, rd);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(2);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
